lay2_seq: RTL and testbench
===========================

Name: lay2_seq

Overview:
- Frame sequencer/collector wrapped around the second network layer.
- Upstream side: accepts a 4-word float32 hidden-layer vector over a valid/ready stream.
- Layer side: presents the vector as stable x0..x3, pulses the layer's start, and waits for its one-cycle result pulse.
- Downstream side: returns the float32 result plus a thresholded class bit over a valid/ready output with backpressure, and flags a watchdog timeout if the layer never answers.

Parameters:
- TIMEOUT, 8'd64: maximum cycles spent in WAIT before the frame is aborted.
- THRESH, 32'h3F000000: positive float32 decision threshold (0.5).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-high reset (asserted when 1).
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  32  float32 word; beats arrive in order x0, x1, x2, x3.
- lay_en  output  1  one-cycle start pulse to the layer.
- lay_x0, lay_x1, lay_x2, lay_x3  output  32 each  held operand vector.
- lay_valid  input  1  layer result pulse (one cycle).
- lay_y  input  32  layer result, sampled when lay_valid=1.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_y  output  32  captured result; 0 on timeout.
- out_class  output  1  1 when out_y >= THRESH.
- out_timeout  output  1  1 when the frame was aborted by the watchdog.
- busy  output  1  1 in FIRE, WAIT or OUT.
- frame_cnt  output  8  count of completed output handshakes; wraps 255->0.

Behaviour:
- Reset state: FSM in COLLECT. Beat index 0. All outputs 0, including lay_x0..3, out_*, frame_cnt, lay_en and busy.
- Reset exception: in_ready is combinational and equals 1 in COLLECT, so it reads 1 during and after reset.
- Reset mid-operation: takes effect immediately. Any partial frame or pending result is discarded.
- FSM states: COLLECT, FIRE, WAIT, OUT.
- COLLECT:
  - in_ready=1.
  - Each cycle with in_valid=1, store in_data into lay_x[idx] and increment the 2-bit idx.
  - When the beat with idx=3 is accepted, clear idx to 0 and go to FIRE.
  - Words with in_valid=0 are not counted.
- FIRE (exactly 1 cycle):
  - lay_en=1, registered, so it is high the cycle after the 4th beat.
  - Load the watchdog counter with TIMEOUT.
  - Go to WAIT.
- WAIT:
  - lay_en=0; lay_x0..3 held stable.
  - If lay_valid=1: capture lay_y into out_y, set out_class = (lay_y[31]==0 && lay_y[30:0] >= THRESH[30:0]), set out_timeout=0, go to OUT.
  - Else if the counter is 0: set out_y=0, out_class=0, out_timeout=1, go to OUT.
  - Else decrement the counter.
  - lay_valid has priority over timeout when both occur in the same cycle.
- OUT:
  - out_valid=1; out_y, out_class and out_timeout held stable.
  - While out_ready=1: drop out_valid the next cycle, increment frame_cnt, go to COLLECT.
  - While out_ready=0: remain in OUT indefinitely; in_ready=0.
- lay_valid outside WAIT is ignored and does not change any output.
- in_ready=0 in FIRE, WAIT and OUT, so upstream stalls; in_data there is ignored.
- Latency:
  - 4th beat accepted at cycle N: lay_en high at N+1, FSM in WAIT from N+2.
  - lay_valid at cycle M: out_valid high at M+1.
  - Timeout: out_valid rises TIMEOUT+2 cycles after lay_en.
- Negative-zero and negative results always give class 0.
- The comparison is unsigned on bits [30:0]. This is valid for a positive THRESH only; THRESH is restricted to positive values.

Test Plan:
1. Nominal: send beats 3F800000, 00000000, 3F800000, BF800000 back-to-back with no gaps. Then:
   - lay_en is high for exactly 1 cycle, 1 cycle after the 4th beat.
   - lay_x0..3 equal the sent words.
   - The bench model returns lay_y=3F400000 after 20 cycles.
   - Result: out_valid=1, out_y=3F400000, out_class=1, out_timeout=0; after the handshake frame_cnt=1.
2. Threshold edges: lay_y=3F000000 -> class 1. lay_y=3EFFFFFF -> class 0. lay_y=3E800000 -> class 0. lay_y=BF400000 -> class 0.
3. Gapped input: in_valid toggles 1,0,0,1,0,1,1 -> exactly 4 words captured in order; lay_en fires only after the 4th accepted beat.
4. Timeout: the layer never asserts lay_valid -> out_valid rises 66 cycles after lay_en with out_timeout=1, out_y=0, out_class=0. A lay_valid arriving afterwards in OUT is ignored.
5. Backpressure: hold out_ready=0 for 5 cycles -> out_* stable, in_ready=0, and in_valid words are not captured. Raise out_ready -> one handshake, then COLLECT with in_ready=1.
6. Reset mid-WAIT: assert rst_n=1 for 2 cycles -> all outputs 0, in_ready=1, frame_cnt=0. A following full frame completes normally with idx starting from x0.

Source files
------------

// File: rtl/lay2_seq.sv
// Frame sequencer around the second network layer: gathers a 4-word float32
// vector, fires the layer, waits for its result (with a watchdog) and hands it on.
module lay2_seq #(
  parameter logic [7:0]  TIMEOUT = 8'd64,
  parameter logic [31:0] THRESH  = 32'h3F000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        lay_en,
  output logic [31:0] lay_x0,
  output logic [31:0] lay_x1,
  output logic [31:0] lay_x2,
  output logic [31:0] lay_x3,
  input  logic        lay_valid,
  input  logic [31:0] lay_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_class,
  output logic        out_timeout,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_FIRE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  wdog;
  logic [31:0] x_q [4];
  logic        above_thresh;

  assign in_ready = (state == S_COLLECT);

  // Sign bit set (including -0.0) never classifies; magnitude compare is valid
  // because THRESH is positive.
  assign above_thresh = !lay_y[31] && (lay_y[30:0] >= THRESH[30:0]);

  assign lay_x0 = x_q[0];
  assign lay_x1 = x_q[1];
  assign lay_x2 = x_q[2];
  assign lay_x3 = x_q[3];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= S_COLLECT;
      idx         <= 2'd0;
      wdog        <= 8'd0;
      lay_en      <= 1'b0;
      out_valid   <= 1'b0;
      out_y       <= 32'd0;
      out_class   <= 1'b0;
      out_timeout <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 8'd0;
      // NOTE: the operand array is reset because it drives visible outputs
      // that must read 0 after reset; a pure storage RAM would not need this.
      for (int i = 0; i < 4; i++) x_q[i] <= 32'd0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_valid) begin
            x_q[idx] <= in_data;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) begin
              state  <= S_FIRE;
              lay_en <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          lay_en <= 1'b0;
          wdog   <= TIMEOUT;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (lay_valid) begin
            out_y       <= lay_y;
            out_class   <= above_thresh;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_OUT;
          end else if (wdog == 8'd0) begin
            out_y       <= 32'd0;
            out_class   <= 1'b0;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= S_OUT;
          end else begin
            wdog <= wdog - 8'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
            busy      <= 1'b0;
            state     <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_lay2_seq.sv
// Directed self-checking bench for lay2_seq; inputs driven and outputs sampled
// on the falling clock edge.
module tb_lay2_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        lay_en;
  logic [31:0] lay_x0, lay_x1, lay_x2, lay_x3;
  logic        lay_valid;
  logic [31:0] lay_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_class;
  logic        out_timeout;
  logic        busy;
  logic [7:0]  frame_cnt;

  int vectors;
  int miscompares;
  int exp_frames;

  lay2_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lay_en     (lay_en),
    .lay_x0     (lay_x0),
    .lay_x1     (lay_x1),
    .lay_x2     (lay_x2),
    .lay_x3     (lay_x3),
    .lay_valid  (lay_valid),
    .lay_y      (lay_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_class  (out_class),
    .out_timeout(out_timeout),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives four back-to-back beats; returns on the falling edge where lay_en should be high.
  task automatic send_beats(input logic [31:0] w0, w1, w2, w3);
    in_valid = 1'b1; in_data = w0; @(negedge clk);
    in_data = w1; @(negedge clk);
    in_data = w2; @(negedge clk);
    in_data = w3; @(negedge clk);
    in_valid = 1'b0; in_data = 32'h0;
  endtask

  // Pulses lay_valid after 'delay' cycles; returns where out_valid should be high.
  task automatic layer_respond(input logic [31:0] y, input int delay);
    repeat (delay) @(negedge clk);
    lay_valid = 1'b1; lay_y = y;
    @(negedge clk);
    lay_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({lay_en, out_valid, out_class, out_timeout, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b expected 00000", {lay_en, out_valid, out_class, out_timeout, busy});
    end
    vectors++;
    if ((lay_x0 | lay_x1 | lay_x2 | lay_x3 | out_y) !== 32'h0 || frame_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_data got x0=%h x1=%h x2=%h x3=%h y=%h cnt=%0d expected all 0",
               lay_x0, lay_x1, lay_x2, lay_x3, out_y, frame_cnt);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_nominal();
    send_beats(32'h3F800000, 32'h00000000, 32'h3F800000, 32'hBF800000);
    vectors++;
    if (lay_en !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_fire got lay_en=%b busy=%b in_ready=%b expected 1/1/0", lay_en, busy, in_ready);
    end
    vectors++;
    if (lay_x0 !== 32'h3F800000 || lay_x1 !== 32'h0 || lay_x2 !== 32'h3F800000 || lay_x3 !== 32'hBF800000) begin
      miscompares++;
      $display("FAIL nominal_x got %h %h %h %h expected 3f800000 00000000 3f800000 bf800000",
               lay_x0, lay_x1, lay_x2, lay_x3);
    end
    @(negedge clk);
    vectors++;
    if (lay_en !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_en_pulse got %b expected 0", lay_en);
    end
    layer_respond(32'h3F400000, 19);
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 32'h3F400000 || out_class !== 1'b1 || out_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_out got v=%b y=%h c=%b t=%b expected 1/3f400000/1/0",
               out_valid, out_y, out_class, out_timeout);
    end
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || frame_cnt !== 8'(exp_frames) || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_done got v=%b cnt=%0d in_ready=%b busy=%b expected 0/%0d/1/0",
               out_valid, frame_cnt, in_ready, busy, exp_frames);
    end
  endtask

  task automatic test_threshold();
    logic [31:0] ys [4];
    logic        cls [4];
    ys  = '{32'h3F000000, 32'h3EFFFFFF, 32'h3E800000, 32'hBF400000};
    cls = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send_beats(32'h1, 32'h2, 32'h3, 32'h4);
      layer_respond(ys[i], 1);
      vectors++;
      if (out_valid !== 1'b1 || out_y !== ys[i] || out_class !== cls[i]) begin
        miscompares++;
        $display("FAIL thresh_%0d got v=%b y=%h c=%b expected 1/%h/%b", i, out_valid, out_y, out_class, ys[i], cls[i]);
      end
      handshake();
    end
    vectors++;
    if (frame_cnt !== 8'(exp_frames)) begin
      miscompares++;
      $display("FAIL thresh_cnt got %0d expected %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_gapped();
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = 32'h11110000 + 32'(i);
      @(negedge clk);
      vectors++;
      if (lay_en !== (i == 6)) begin
        miscompares++;
        $display("FAIL gapped_en_%0d got %b expected %b", i, lay_en, (i == 6));
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (lay_x0 !== 32'h11110000 || lay_x1 !== 32'h11110003 || lay_x2 !== 32'h11110005 || lay_x3 !== 32'h11110006) begin
      miscompares++;
      $display("FAIL gapped_x got %h %h %h %h expected 11110000 11110003 11110005 11110006",
               lay_x0, lay_x1, lay_x2, lay_x3);
    end
    layer_respond(32'h3F800000, 2);
    handshake();
  endtask

  task automatic test_timeout();
    int n;
    send_beats(32'h5, 32'h6, 32'h7, 32'h8);
    vectors++;
    if (lay_en !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_fire got %b expected 1", lay_en);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 66) begin
      miscompares++;
      $display("FAIL timeout_latency got %0d cycles expected 66", n);
    end
    vectors++;
    if (out_timeout !== 1'b1 || out_y !== 32'h0 || out_class !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_out got t=%b y=%h c=%b expected 1/00000000/0", out_timeout, out_y, out_class);
    end
    lay_valid = 1'b1; lay_y = 32'h3F800000;
    @(negedge clk);
    lay_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 32'h0 || out_timeout !== 1'b1 || out_class !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_late_valid got v=%b y=%h t=%b c=%b expected 1/00000000/1/0",
               out_valid, out_y, out_timeout, out_class);
    end
    handshake();
    vectors++;
    if (frame_cnt !== 8'(exp_frames) || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_done got cnt=%0d v=%b expected %0d/0", frame_cnt, out_valid, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    send_beats(32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000);
    layer_respond(32'h40400000, 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_y !== 32'h40400000 || out_class !== 1'b1 || in_ready !== 1'b0 ||
          lay_x0 !== 32'h40000000) begin
        miscompares++;
        $display("FAIL stall_%0d got v=%b y=%h c=%b in_ready=%b x0=%h expected 1/40400000/1/0/40000000",
                 i, out_valid, out_y, out_class, in_ready, lay_x0);
      end
    end
    in_valid = 1'b0;
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'(exp_frames) || lay_x0 !== 32'h40000000) begin
      miscompares++;
      $display("FAIL stall_release got v=%b in_ready=%b cnt=%0d x0=%h expected 0/1/%0d/40000000",
               out_valid, in_ready, frame_cnt, exp_frames, lay_x0);
    end
  endtask

  task automatic test_reset_mid_wait();
    send_beats(32'hA, 32'hB, 32'hC, 32'hD);
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_busy got busy=%b in_ready=%b expected 1/0", busy, in_ready);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({lay_en, out_valid, busy} !== 3'b0 || frame_cnt !== 8'd0 || in_ready !== 1'b1 || lay_x0 !== 32'h0) begin
      miscompares++;
      $display("FAIL midwait_async got en=%b v=%b busy=%b cnt=%0d in_ready=%b x0=%h expected 0/0/0/0/1/0",
               lay_en, out_valid, busy, frame_cnt, in_ready, lay_x0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_frames = 0;
    send_beats(32'h21, 32'h22, 32'h23, 32'h24);
    vectors++;
    if (lay_en !== 1'b1 || lay_x0 !== 32'h21 || lay_x1 !== 32'h22 || lay_x2 !== 32'h23 || lay_x3 !== 32'h24) begin
      miscompares++;
      $display("FAIL midwait_frame got en=%b x=%h %h %h %h expected 1 00000021 00000022 00000023 00000024",
               lay_en, lay_x0, lay_x1, lay_x2, lay_x3);
    end
    layer_respond(32'h3F000000, 4);
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 32'h3F000000 || out_class !== 1'b1) begin
      miscompares++;
      $display("FAIL midwait_out got v=%b y=%h c=%b expected 1/3f000000/1", out_valid, out_y, out_class);
    end
    handshake();
    vectors++;
    if (frame_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL midwait_cnt got %0d expected 1", frame_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_frames  = 0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    lay_valid   = 1'b0;
    lay_y       = 32'h0;
    out_ready   = 1'b0;
    test_reset();
    test_nominal();
    test_threshold();
    test_gapped();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
